usb_cdc_rx_line_assembler: RTL

USB_CDC_RX_LINE_ASSEMBLER -- requirements
Module: usb_cdc_rx_line_assembler

---
 rtl/usb_cdc_pkg.sv | 22 ++
 rtl/usb_cdc_line_ram.sv | 24 ++
 rtl/usb_cdc_rx_line_assembler.sv | 137 +++++++++++++
 3 files changed

// File: rtl/usb_cdc_pkg.sv
// Shared types and defaults for the USB CDC receive line assembler.
// States, line completion codes and the default line buffer depth.
package usb_cdc_pkg;

    localparam int MAX_LEN_DEFAULT = 32;
    localparam int TMO_W_DEFAULT   = 16;

    localparam logic [7:0] LF_CHAR = 8'h0A;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_HOLD    = 2'd2
    } line_state_t;

    typedef enum logic [1:0] {
        LS_EOL      = 2'b00,
        LS_OVERFLOW = 2'b01,
        LS_TIMEOUT  = 2'b10
    } line_status_t;

endpackage

// File: rtl/usb_cdc_line_ram.sv
// Line buffer: DEPTH x 8 storage, synchronous write, asynchronous read.
// The consumer reads through the async port while a line is held.
module usb_cdc_line_ram #(
    parameter int DEPTH = 32
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [7:0]               wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [7:0]               rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/usb_cdc_rx_line_assembler.sv
// Pops bytes from the CDC RX FIFO and assembles them into terminated lines,
// closing a line on terminator, buffer full or inter-byte idle timeout.
//
// state      | meaning
// -----------+-----------------------------------------------
// ST_IDLE    | no bytes buffered (count = 0), popping allowed
// ST_COLLECT | partial line buffered, idle timer running
// ST_HOLD    | complete line offered to the consumer, no pops
module usb_cdc_rx_line_assembler
    import usb_cdc_pkg::*;
#(
    parameter int MAX_LEN = MAX_LEN_DEFAULT,
    parameter int TMO_W   = TMO_W_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [7:0]                 eol_char,
    input  logic                       drop_lf,
    input  logic [TMO_W-1:0]           timeout,
    output logic                       rx_fifo_rd,
    input  logic [7:0]                 rx_fifo_rdata,
    input  logic                       rx_fifo_empty,
    output logic                       line_valid,
    output logic [$clog2(MAX_LEN):0]   line_len,
    output logic [1:0]                 line_status,
    input  logic [$clog2(MAX_LEN)-1:0] rd_addr,
    output logic [7:0]                 rd_data,
    input  logic                       line_ack
);

    localparam int AW = $clog2(MAX_LEN);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(MAX_LEN);

    line_state_t  state, state_nxt;
    line_status_t status_q, status_nxt;
    logic [CW-1:0]    count, count_nxt;
    logic [CW-1:0]    len_q, len_nxt;
    logic [TMO_W-1:0] idle_cnt, idle_nxt;

    logic pop;
    logic is_eol;
    logic is_drop;
    logic wr_en;

    // Reset gates the pop so nothing is lost from the FIFO during the reset cycle.
    assign pop     = en & ~rx_fifo_empty & (state != ST_HOLD) & ~rst;
    assign is_eol  = (rx_fifo_rdata == eol_char);
    assign is_drop = drop_lf & (rx_fifo_rdata == LF_CHAR) & ~is_eol;
    assign wr_en   = pop & ~is_eol & ~is_drop;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            count    <= '0;
            idle_cnt <= '0;
            len_q    <= '0;
            status_q <= LS_EOL;
        end else begin
            state    <= state_nxt;
            count    <= count_nxt;
            idle_cnt <= idle_nxt;
            len_q    <= len_nxt;
            status_q <= status_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        count_nxt  = count;
        idle_nxt   = idle_cnt;
        len_nxt    = len_q;
        status_nxt = status_q;

        case (state)
            ST_IDLE, ST_COLLECT: begin
                if (pop && is_eol) begin
                    len_nxt    = count;
                    status_nxt = LS_EOL;
                    idle_nxt   = '0;
                    state_nxt  = ST_HOLD;
                end else if (pop && is_drop) begin
                    state_nxt = state;
                end else if (wr_en) begin
                    count_nxt = count + CW'(1);
                    idle_nxt  = '0;
                    if (count_nxt == FULL_CNT) begin
                        len_nxt    = FULL_CNT;
                        status_nxt = LS_OVERFLOW;
                        state_nxt  = ST_HOLD;
                    end else begin
                        state_nxt = ST_COLLECT;
                    end
                end else if (state == ST_COLLECT && timeout != '0 && en) begin
                    // Flush one cycle after the idle count reaches the limit.
                    if (idle_cnt >= timeout) begin
                        len_nxt    = count;
                        status_nxt = LS_TIMEOUT;
                        state_nxt  = ST_HOLD;
                    end else begin
                        idle_nxt = idle_cnt + TMO_W'(1);
                    end
                end
            end
            ST_HOLD: begin
                if (line_ack) begin
                    count_nxt = '0;
                    idle_nxt  = '0;
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                count_nxt = '0;
                idle_nxt  = '0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign rx_fifo_rd  = pop;
    assign line_valid  = (state == ST_HOLD);
    assign line_len    = len_q;
    assign line_status = status_q;

    usb_cdc_line_ram #(
        .DEPTH (MAX_LEN)
    ) u_line_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (count[AW-1:0]),
        .wdata (rx_fifo_rdata),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

endmodule
